// File: rtl/plic_pkg.sv
// Shared PLIC types and helpers: priority/ID typedefs, tree node, node compare,
// tree depth and pipeline latency.
package plic_pkg;

`ifndef PLIC_IRQ_NUM
`define PLIC_IRQ_NUM 8
`endif
`ifndef PLIC_LEV_WIDTH
`define PLIC_LEV_WIDTH 3
`endif

  localparam int IRQ_N = `PLIC_IRQ_NUM;
  localparam int LEV_W = `PLIC_LEV_WIDTH;
  localparam int ID_W  = $clog2(IRQ_N + 1);

  typedef logic [LEV_W-1:0] lev_t;
  typedef logic [ID_W-1:0]  id_t;

  typedef struct packed {
    lev_t prio;
    id_t  id;
  } node_t;

  // Strict compare: ties keep the lower-index (lower ID) input.
  function automatic node_t max_node(node_t lo, node_t hi);
    return (lo.prio < hi.prio) ? hi : lo;
  endfunction

  function automatic int depth(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int latency(int n, int se);
    return (se == 0) ? 1 : (depth(n) + se - 1) / se;
  endfunction

endpackage

// File: rtl/plic_prio_level.sv
// One combinational comparator level of the PLIC priority tree;
// halves the node array.
module plic_prio_level
  import plic_pkg::*;
#(
  parameter int N = 1
) (
  input  node_t a [2*N],
  output node_t y [N]
);

  for (genvar j = 0; j < N; j++) begin : g_node
    assign y[j] = max_node(a[2*j], a[2*j+1]);
  end

endmodule

// File: rtl/plic_prio_pipe.sv
// Pipelined PLIC priority tree with threshold compare on the final level.
// Optional stall input enabled by PLIC_PRIO_PIPE_STALL_EN.
module plic_prio_pipe
  import plic_pkg::*;
#(
  parameter  int IRQ_NUM     = IRQ_N,
  parameter  int LEV_WIDTH   = LEV_W,
  parameter  int STAGE_EVERY = 1,
  localparam int IRQ_WIDTH   = $clog2(IRQ_NUM + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef PLIC_PRIO_PIPE_STALL_EN
  input  logic                 stall_i,
`endif
  input  logic                 valid_i,
  input  logic [IRQ_NUM-1:0]   pend_i,
  input  logic [IRQ_NUM-1:0]   en_i,
  input  logic [LEV_WIDTH-1:0] prio_i [IRQ_NUM],
  input  logic [LEV_WIDTH-1:0] thold_i,
  output logic                 valid_o,
  output logic [IRQ_WIDTH-1:0] id_o,
  output logic [LEV_WIDTH-1:0] prio_o,
  output logic                 irq_o
);

  localparam int DEPTH  = depth(IRQ_NUM);
  localparam int LEAVES = 1 << DEPTH;

  logic  adv;
  logic  irq_r;
  logic  vld [DEPTH+1];
  lev_t  thd [DEPTH];
  node_t src [DEPTH+1][LEAVES];

`ifdef PLIC_PRIO_PIPE_STALL_EN
  assign adv = ~stall_i;
`else
  assign adv = 1'b1;
`endif

  assign vld[0] = valid_i;
  assign thd[0] = thold_i;

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < IRQ_NUM) begin : g_src
      lev_t p;
      assign p = (pend_i[i] & en_i[i]) ? prio_i[i] : '0;
      assign src[0][i].prio = p;
      assign src[0][i].id   = (p != '0) ? id_t'(i + 1) : '0;
    end else begin : g_pad
      assign src[0][i] = '0;
    end
  end

  for (genvar k = 1; k <= DEPTH; k++) begin : g_lvl
    localparam int W = LEAVES >> k;
    localparam bit REG = (k == DEPTH) ||
                         (STAGE_EVERY != 0 && (k % STAGE_EVERY) == 0);

    node_t a [2*W];
    node_t y [W];

    for (genvar j = 0; j < 2*W; j++) begin : g_in
      assign a[j] = src[k-1][j];
    end

    plic_prio_level #(.N(W)) u_level (
      .a (a),
      .y (y)
    );

    if (REG) begin : g_reg
      node_t q [W];
      logic  v;
      lev_t  t;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v <= 1'b0;
        end else if (adv) begin
          v <= vld[k-1];
          t <= thd[k-1];
          q <= y;
        end
      end

      assign vld[k] = v;
      for (genvar j = 0; j < W; j++) begin : g_out
        assign src[k][j] = q[j];
      end
      if (k < DEPTH) begin : g_thd
        assign thd[k] = t;
      end
    end else begin : g_comb
      assign vld[k] = vld[k-1];
      assign thd[k] = thd[k-1];
      for (genvar j = 0; j < W; j++) begin : g_out
        assign src[k][j] = y[j];
      end
    end

    for (genvar j = W; j < LEAVES; j++) begin : g_zero
      assign src[k][j] = '0;
    end

    // Threshold compare rides in the final register with its vector.
    if (k == DEPTH) begin : g_irq
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          irq_r <= 1'b0;
        end else if (adv) begin
          irq_r <= vld[k-1] && (y[0].prio > thd[k-1]);
        end
      end
    end
  end

  assign valid_o = vld[DEPTH];
  assign id_o    = valid_o ? src[DEPTH][0].id : '0;
  assign prio_o  = valid_o ? src[DEPTH][0].prio : '0;
  assign irq_o   = valid_o & irq_r;

endmodule

// File: tb/tb_plic_prio_pipe.sv
// Directed bench for plic_prio_pipe: IRQ_NUM=8, LEV_WIDTH=3, STAGE_EVERY=1 (L=3).
// Stall scenario runs when PLIC_PRIO_PIPE_STALL_EN is defined.
module tb_plic_prio_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       valid;
  logic [7:0] pend;
  logic [7:0] en;
  logic [2:0] prio [8];
  logic [2:0] thold;
  logic       valid_o;
  logic [3:0] id_o;
  logic [2:0] prio_o;
  logic       irq_o;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  plic_prio_pipe #(
    .IRQ_NUM     (8),
    .LEV_WIDTH   (3),
    .STAGE_EVERY (1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
`ifdef PLIC_PRIO_PIPE_STALL_EN
    .stall_i (stall),
`endif
    .valid_i (valid),
    .pend_i  (pend),
    .en_i    (en),
    .prio_i  (prio),
    .thold_i (thold),
    .valid_o (valid_o),
    .id_o    (id_o),
    .prio_o  (prio_o),
    .irq_o   (irq_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(string tag, logic v, logic [3:0] id,
                         logic [2:0] p, logic irq);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".id"}, 32'(id_o), 32'(id));
    chk({tag, ".prio"}, 32'(prio_o), 32'(p));
    chk({tag, ".irq"}, 32'(irq_o), 32'(irq));
  endtask

  task automatic clr_prio();
    for (int i = 0; i < 8; i++) prio[i] = 3'd0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    valid = 1'b1;
    pend = 8'hFF;
    en = 8'hFF;
    clr_prio();
    thold = 3'd0;
    step();
    step();
    chk_out("reset", 1'b0, 4'd0, 3'd0, 1'b0);
    rst = 1'b0;
    valid = 1'b0;
    step();

    // tie: lowest ID wins
    for (int i = 0; i < 8; i++) prio[i] = 3'd5;
    pend = 8'hFF; en = 8'hFF; thold = 3'd2; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    chk("tie.early", 32'(valid_o), 32'd0);
    step();
    chk_out("tie", 1'b1, 4'd1, 3'd5, 1'b1);
    step();
    chk_out("tie.after", 1'b0, 4'd0, 3'd0, 1'b0);

    // masking
    clr_prio();
    prio[6] = 3'd7; prio[2] = 3'd4;
    pend = 8'h44; en = 8'h04; valid = 1'b1;
    step();
    en = 8'h44;
    step();
    valid = 1'b0;
    step();
    chk_out("mask.off", 1'b1, 4'd3, 3'd4, 1'b1);
    step();
    chk_out("mask.on", 1'b1, 4'd7, 3'd7, 1'b1);

    // threshold boundary
    clr_prio();
    prio[0] = 3'd3; pend = 8'h01; en = 8'h01; thold = 3'd3; valid = 1'b1;
    step();
    thold = 3'd2;
    step();
    valid = 1'b0;
    thold = 3'd0;
    step();
    chk_out("thold.eq", 1'b1, 4'd1, 3'd3, 1'b0);
    step();
    chk_out("thold.gt", 1'b1, 4'd1, 3'd3, 1'b1);

    // threshold travels with its vector
    prio[0] = 3'd4; thold = 3'd5; valid = 1'b1;
    step();
    thold = 3'd1;
    step();
    valid = 1'b0;
    thold = 3'd7;
    step();
    chk_out("align.a", 1'b1, 4'd1, 3'd4, 1'b0);
    step();
    chk_out("align.b", 1'b1, 4'd1, 3'd4, 1'b1);

    // nothing pending: valid result with ID 0
    pend = 8'h00; thold = 3'd0; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    step();
    chk_out("none", 1'b1, 4'd0, 3'd0, 1'b0);

    // highest source wins over lower ones
    prio[0] = 3'd2; prio[5] = 3'd6; prio[7] = 3'd5;
    pend = 8'hA1; en = 8'hFF; thold = 3'd6; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    step();
    chk_out("max", 1'b1, 4'd6, 3'd6, 1'b0);

    // reset mid-flight discards in-flight results
    step();
    valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    valid = 1'b0;
    step();
    chk("rst.flush", 32'(valid_o), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out("rst.idle", 1'b0, 4'd0, 3'd0, 1'b0);
    end

`ifdef PLIC_PRIO_PIPE_STALL_EN
    clr_prio();
    prio[0] = 3'd2; prio[7] = 3'd6;
    en = 8'hFF; thold = 3'd3;
    pend = 8'h01; valid = 1'b1;
    step();
    pend = 8'h80;
    step();
    valid = 1'b0;
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stall.hold", 32'(valid_o), 32'd0);
    end
    stall = 1'b0;
    step();
    chk_out("stall.r1", 1'b1, 4'd1, 3'd2, 1'b0);
    step();
    chk_out("stall.r2", 1'b1, 4'd8, 3'd6, 1'b1);
    step();
    chk("stall.end", 32'(valid_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
